// File: rtl/lcd1602_pkg.sv
// Shared constants and state encoding for the LCD1602 text scroller
// and neighbouring LCD frame sources.
package lcd1602_pkg;

  localparam int         LCD_COLS   = 16;
  localparam int         LCD_ROWS   = 2;
  localparam int         LCD_CHARS  = 32;
  localparam logic [7:0] CHAR_SPACE = 8'h20;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    SEND  = 2'd2
  } scroll_state_t;

endpackage

// File: rtl/lcd1602_text_scroller_if.sv
// Character request stream from the scroller to the HD44780 write stage.
interface lcd1602_text_scroller_if;

  logic       char_valid;
  logic       char_ready;
  logic       char_row;
  logic [3:0] char_col;
  logic [7:0] char_data;

  modport master (
    output char_valid, char_row, char_col, char_data,
    input  char_ready
  );

  modport slave (
    input  char_valid, char_row, char_col, char_data,
    output char_ready
  );

endinterface

// File: rtl/lcd_tick_gen.sv
// Free-running period counter; emits a one-cycle tick each time it wraps.
module lcd_tick_gen #(
  parameter int step_cycles = 1000
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic tick_o
);

  localparam int            CW   = (step_cycles > 1) ? $clog2(step_cycles) : 1;
  localparam logic [CW-1:0] LAST = CW'(step_cycles - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tick_q, tick_d;

  // Next count and wrap detection
  always_comb begin
    cnt_d  = cnt_q + CW'(1);
    tick_d = 1'b0;
    if (cnt_q == LAST) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      tick_d = 1'b0;
    end
  end

  // Counter and tick registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/lcd1602_text_scroller.sv
// Message ribbon buffer with a scrolling 2x16 window, streamed one
// character per handshake to the LCD write stage.
module lcd1602_text_scroller
  import lcd1602_pkg::*;
#(
  parameter int clk_mhz = 27,
  parameter int msg_len = 32,
  parameter int step_ms = 300,
  parameter int w_key   = 8,
  localparam int AW     = $clog2(msg_len)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [w_key-1:0]     keys_i,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [7:0]           wr_char_i,
  lcd1602_text_scroller_if.master char_m,
  output logic                 frame_done_o,
  output logic [AW-1:0]        offset_o,
  output logic                 paused_o,
  output logic                 dir_right_o,
  output logic                 busy_o
);

  localparam int            SW        = AW + 2;
  localparam logic [SW-1:0] LEN       = SW'(msg_len);
  localparam logic [SW-1:0] LEN2      = SW'(2 * msg_len);
  localparam logic [AW-1:0] LAST_ADDR = AW'(msg_len - 1);
  localparam logic [4:0]    LAST_K    = 5'(LCD_CHARS - 1);

  scroll_state_t state_q, state_d;
  logic [7:0]    mem_q [msg_len];
  logic [AW-1:0] clr_q, clr_d;
  logic [AW-1:0] offset_q, offset_d;
  logic [4:0]    k_q, k_d;
  logic          pend_q, pend_d;
  logic          paused_q, paused_d;
  logic          dir_q, dir_d;
  logic          valid_q, valid_d;
  logic          row_q, row_d;
  logic [3:0]    col_q, col_d;
  logic [7:0]    data_q, data_d;
  logic          done_q, done_d;
  logic [1:0]    key_s1_q, key_s2_q, key_prev_q;
  logic [1:0]    key_rise_s;
  logic          tick_s, xfer_s, wr_ok_s, unused_keys_s;
  logic [SW-1:0] sum_s;
  logic [AW-1:0] rd_addr_s;

  lcd_tick_gen #(
    .step_cycles(clk_mhz * 1000 * step_ms)
  ) u_tick (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .tick_o(tick_s)
  );

  // Only the pause and direction keys matter; the rest of the bus is ignored.
  assign unused_keys_s = ^keys_i;
  assign key_rise_s    = key_s2_q & ~key_prev_q;
  assign xfer_s        = valid_q & char_m.char_ready;
  assign wr_ok_s       = wr_en_i && !rst_i && (state_q != CLEAR)
                         && ({1'b0, wr_addr_i} < (AW+1)'(msg_len));

  // Ribbon index (offset + k) mod msg_len; k < 32 means at most two wraps
  always_comb begin
    sum_s = SW'(offset_q) + SW'(k_q);
    if (sum_s >= LEN2) begin
      rd_addr_s = AW'(sum_s - LEN2);
    end else if (sum_s >= LEN) begin
      rd_addr_s = AW'(sum_s - LEN);
    end else begin
      rd_addr_s = AW'(sum_s);
    end
  end

  // FSM next state, payload staging, offset stepping and pending flag
  always_comb begin
    state_d  = state_q;
    clr_d    = clr_q;
    k_d      = k_q;
    pend_d   = pend_q;
    offset_d = offset_q;
    paused_d = paused_q ^ key_rise_s[0];
    dir_d    = dir_q ^ key_rise_s[1];
    valid_d  = valid_q;
    row_d    = row_q;
    col_d    = col_q;
    data_d   = data_q;
    done_d   = 1'b0;

    case (state_q)
      CLEAR: begin
        if (clr_q == LAST_ADDR) begin
          // The power-up frame is sent straight away, so nothing is left pending.
          clr_d   = '0;
          k_d     = '0;
          state_d = SEND;
        end else begin
          clr_d   = clr_q + AW'(1);
        end
      end
      IDLE: begin
        if (pend_q) begin
          pend_d  = 1'b0;
          k_d     = '0;
          state_d = SEND;
        end else begin
          state_d = IDLE;
        end
      end
      SEND: begin
        if (!valid_q) begin
          valid_d = 1'b1;
          row_d   = k_q[4];
          col_d   = k_q[3:0];
          data_d  = mem_q[rd_addr_s];
        end else if (xfer_s) begin
          valid_d = 1'b0;
          if (k_q == LAST_K) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end else begin
            k_d     = k_q + 5'd1;
          end
        end else begin
          valid_d = 1'b1;
        end
      end
      default: begin
        state_d = CLEAR;
        clr_d   = '0;
        valid_d = 1'b0;
      end
    endcase

    // Ticks and host writes may land in any state; extra requests coalesce.
    if (tick_s && !paused_q) begin
      pend_d = 1'b1;
      if (dir_q) begin
        offset_d = (offset_q == '0) ? LAST_ADDR : offset_q - AW'(1);
      end else begin
        offset_d = (offset_q == LAST_ADDR) ? '0 : offset_q + AW'(1);
      end
    end else begin
      offset_d = offset_q;
    end
    if (wr_ok_s) begin
      pend_d = 1'b1;
    end else begin
      pend_d = pend_d;
    end
  end

  // Control, payload and key synchroniser registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= CLEAR;
      clr_q      <= '0;
      k_q        <= '0;
      pend_q     <= 1'b0;
      offset_q   <= '0;
      paused_q   <= 1'b0;
      dir_q      <= 1'b0;
      valid_q    <= 1'b0;
      row_q      <= 1'b0;
      col_q      <= 4'd0;
      data_q     <= CHAR_SPACE;
      done_q     <= 1'b0;
      key_s1_q   <= 2'b00;
      key_s2_q   <= 2'b00;
      key_prev_q <= 2'b00;
    end else begin
      state_q    <= state_d;
      clr_q      <= clr_d;
      k_q        <= k_d;
      pend_q     <= pend_d;
      offset_q   <= offset_d;
      paused_q   <= paused_d;
      dir_q      <= dir_d;
      valid_q    <= valid_d;
      row_q      <= row_d;
      col_q      <= col_d;
      data_q     <= data_d;
      done_q     <= done_d;
      key_s1_q   <= keys_i[1:0];
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
    end
  end

  // Message buffer: blanked during CLEAR, otherwise written by the host
  always_ff @(posedge clk_i) begin
    if (state_q == CLEAR) begin
      mem_q[clr_q] <= CHAR_SPACE;
    end else if (wr_ok_s) begin
      mem_q[wr_addr_i] <= wr_char_i;
    end
  end

  assign char_m.char_valid = valid_q;
  assign char_m.char_row   = row_q;
  assign char_m.char_col   = col_q;
  assign char_m.char_data  = data_q;
  assign frame_done_o      = done_q;
  assign offset_o          = offset_q;
  assign paused_o          = paused_q;
  assign dir_right_o       = dir_q;
  assign busy_o            = (state_q != IDLE);

endmodule

// File: tb/tb_lcd1602_text_scroller.sv
// Directed bench for lcd1602_text_scroller with a 1000-cycle scroll step.
module tb_lcd1602_text_scroller;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keys;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_char;
  logic       frame_done;
  logic [4:0] offset;
  logic       paused;
  logic       dir_right;
  logic       busy;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] mdl [32];

  lcd1602_text_scroller_if sif ();

  lcd1602_text_scroller #(
    .clk_mhz(1),
    .msg_len(32),
    .step_ms(1),
    .w_key  (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .keys_i      (keys),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .wr_char_i   (wr_char),
    .char_m      (sif.master),
    .frame_done_o(frame_done),
    .offset_o    (offset),
    .paused_o    (paused),
    .dir_right_o (dir_right),
    .busy_o      (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic write_char(input logic [4:0] addr, input logic [7:0] ch);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_char = ch;
    mdl[addr] = ch;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic press_key(input int idx);
    keys[idx] = 1'b1;
    repeat (4) @(negedge clk);
    keys[idx] = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_frame(input int max_cyc);
    int c = 0;
    while (!sif.char_valid && c < max_cyc) begin
      @(negedge clk);
      c++;
    end
    check_eq("frame_start", 32'(sif.char_valid), 32'd1);
  endtask

  task automatic wait_clear(input string tag);
    int c = 0;
    while (!sif.char_valid && c < 200) begin
      if (c == 16) check_eq({tag, "_busy"}, 32'(busy), 32'd1);
      @(negedge clk);
      c++;
    end
    // 32 blanking cycles, then one fetch cycle before the first request
    check_eq({tag, "_latency"}, 32'(c), 32'd33);
  endtask

  // Accepts n_xfer transfers, checking each payload against the model window.
  task automatic collect_frame(input int off, input bit stall, input int n_xfer);
    int          k = 0;
    int          c = 0;
    bit          held = 1'b0;
    logic [12:0] held_p, pay, exp_p;
    logic [4:0]  idx;
    while (k < n_xfer && c < 4000) begin
      sif.char_ready = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      pay = {sif.char_row, sif.char_col, sif.char_data};
      if (held) check_eq("hold", 32'({sif.char_valid, pay}), 32'({1'b1, held_p}));
      if (sif.char_valid && sif.char_ready) begin
        idx   = 5'(off + k);
        exp_p = {k[4], k[3:0], mdl[idx]};
        check_eq($sformatf("xfer%0d", k), 32'(pay), 32'(exp_p));
        k++;
        held = 1'b0;
      end else begin
        held   = sif.char_valid;
        held_p = pay;
      end
      @(negedge clk);
      c++;
    end
    check_eq("xfer_count", 32'(k), 32'(n_xfer));
    if (n_xfer == 32) begin
      check_eq("frame_done", 32'(frame_done), 32'd1);
      check_eq("valid_after", 32'(sif.char_valid), 32'd0);
      @(negedge clk);
      check_eq("done_pulse", 32'(frame_done), 32'd0);
    end
    sif.char_ready = 1'b1;
  endtask

  initial begin
    string msg;
    int    nvalid;
    msg = "0123456789ABCDEFGHIJKLMNOPQRSTUV";
    rst = 1'b1; keys = 8'h00; wr_en = 1'b0; wr_addr = 5'd0; wr_char = 8'h00;
    sif.char_ready = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
    repeat (3) @(negedge clk);

    // Reset state
    check_eq("rst_valid",  32'(sif.char_valid), 32'd0);
    check_eq("rst_rowcol", 32'({sif.char_row, sif.char_col}), 32'd0);
    check_eq("rst_data",   32'(sif.char_data), 32'h20);
    check_eq("rst_done",   32'(frame_done), 32'd0);
    check_eq("rst_offset", 32'(offset), 32'd0);
    check_eq("rst_flags",  32'({paused, dir_right}), 32'd0);
    check_eq("rst_busy",   32'(busy), 32'd1);
    rst = 1'b0;

    // Power-up blank frame
    wait_clear("clear");
    collect_frame(0, 1'b0, 32);
    check_eq("idle_busy", 32'(busy), 32'd0);
    check_eq("offset0", 32'(offset), 32'd0);

    // Load the message, let the write-triggered frames drain, then scroll once
    for (int i = 0; i < 32; i++) write_char(5'(i), msg[i]);
    repeat (200) @(negedge clk);
    check_eq("drained", 32'({busy, sif.char_valid}), 32'd0);
    wait_frame(1200);
    check_eq("offset1", 32'(offset), 32'd1);
    collect_frame(1, 1'b0, 32);

    // Scroll right across the wrap, then left back across it
    press_key(1);
    check_eq("dir_right", 32'(dir_right), 32'd1);
    check_eq("key_no_frame", 32'(busy), 32'd0);
    wait_frame(1200);
    check_eq("offset_r0", 32'(offset), 32'd0);
    collect_frame(0, 1'b0, 32);
    wait_frame(1200);
    check_eq("offset_r31", 32'(offset), 32'd31);
    check_eq("first_V", 32'(sif.char_data), 32'h56);
    collect_frame(31, 1'b0, 32);
    press_key(1);
    check_eq("dir_left", 32'(dir_right), 32'd0);
    wait_frame(1200);
    check_eq("offset_l0", 32'(offset), 32'd0);
    collect_frame(0, 1'b0, 32);

    // Random downstream stalls
    wait_frame(1200);
    check_eq("offset_stall", 32'(offset), 32'd1);
    collect_frame(1, 1'b1, 32);

    // Pause across three step periods, then resume
    press_key(0);
    check_eq("paused_on", 32'(paused), 32'd1);
    nvalid = 0;
    for (int i = 0; i < 3100; i++) begin
      @(negedge clk);
      if (sif.char_valid) nvalid++;
    end
    check_eq("paused_no_frames", 32'(nvalid), 32'd0);
    check_eq("paused_offset", 32'(offset), 32'd1);
    press_key(0);
    check_eq("paused_off", 32'(paused), 32'd0);
    wait_frame(1200);
    check_eq("offset_resume", 32'(offset), 32'd2);
    collect_frame(2, 1'b0, 32);

    // A host write in IDLE triggers a frame showing it
    write_char(5'd3, 8'h2A);
    wait_frame(10);
    collect_frame(2, 1'b0, 32);

    // Reset in the middle of a frame, while k=10 is being presented
    write_char(5'd4, 8'h2B);
    wait_frame(10);
    collect_frame(2, 1'b0, 10);
    @(negedge clk);
    check_eq("k10_valid", 32'({sif.char_valid, sif.char_col}), 32'h1A);
    sif.char_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_eq("abort_valid", 32'(sif.char_valid), 32'd0);
    check_eq("abort_done", 32'(frame_done), 32'd0);
    check_eq("abort_busy", 32'(busy), 32'd1);
    check_eq("abort_offset", 32'(offset), 32'd0);
    rst = 1'b0;
    sif.char_ready = 1'b1;
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
    wait_clear("reclear");
    collect_frame(0, 1'b0, 32);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
